// File: rtl/spike_label_scorer.sv
// spike_label_scorer: scores each presented digit sample against the first
// output-layer spike inside a fixed response window and keeps per-epoch totals.
module spike_label_scorer #(
    parameter int p_sample_num = 30,
    parameter int p_window     = 200,
    parameter int p_epochs     = 400
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic [25:1]                        i_test_vector,
    input  logic [10:1]                        i_label,
    input  logic [10:1]                        i_out_spikes,
    output logic                               o_result_valid,
    output logic [1:0]                         o_result,
    output logic [10:1]                        o_winner,
    output logic [$clog2(p_sample_num+1)-1:0]  o_correct_cnt,
    output logic [$clog2(p_sample_num+1)-1:0]  o_scored_cnt,
    output logic                               o_epoch_done,
    output logic [$clog2(p_sample_num+1)-1:0]  o_epoch_correct,
    output logic [$clog2(p_epochs+1)-1:0]      o_epoch_idx,
    output logic                               o_overrun,
    output logic                               o_label_err
);

    localparam int CW = $clog2(p_sample_num + 1);
    localparam int EW = $clog2(p_epochs + 1);
    localparam int WW = $clog2(p_window + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WINDOW = 2'd1,
        ST_SCORE  = 2'd2
    } state_t;

    // True when exactly one label bit is set.
    function automatic logic is_one_hot(input logic [10:1] v);
        is_one_hot = (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
    endfunction

    // Isolates the lowest-index set bit (bit 1 is the LSB).
    function automatic logic [10:1] lowest_set(input logic [10:1] v);
        lowest_set = v & (~v + 10'd1);
    endfunction

    // Result code: 00 no response, 01 correct, 10 wrong.
    function automatic logic [1:0] score_code(input logic [10:1] win, input logic [10:1] lab);
        if (win == 10'd0) begin
            score_code = 2'b00;
        end else if (win == lab) begin
            score_code = 2'b01;
        end else begin
            score_code = 2'b10;
        end
    endfunction

    state_t          state_r;
    state_t          state_s;
    logic [WW-1:0]   win_cnt_r;
    logic [10:1]     label_r;
    logic [10:1]     winner_r;
    logic            present_s;
    logic            label_ok_s;
    logic [1:0]      code_s;

    assign present_s  = (i_test_vector != 25'd0);
    assign label_ok_s = is_one_hot(i_label);
    assign code_s     = score_code(winner_r, label_r);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state: accept a clean presentation, run the window, score for one cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (present_s && label_ok_s) begin
                    state_s = ST_WINDOW;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WINDOW: begin
                if (win_cnt_r == WW'(p_window - 1)) begin
                    state_s = ST_SCORE;
                end else begin
                    state_s = ST_WINDOW;
                end
            end
            ST_SCORE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Sample context: latched label, window counter and first-spike winner.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            label_r   <= 10'd0;
            win_cnt_r <= '0;
            winner_r  <= 10'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (present_s && label_ok_s) begin
                        label_r   <= i_label;
                        win_cnt_r <= '0;
                        winner_r  <= 10'd0;
                    end
                end
                ST_WINDOW: begin
                    win_cnt_r <= win_cnt_r + WW'(1);
                    if ((winner_r == 10'd0) && (i_out_spikes != 10'd0)) begin
                        winner_r <= lowest_set(i_out_spikes);
                    end
                end
                default: begin
                    win_cnt_r <= win_cnt_r;
                end
            endcase
        end
    end

    // Score outputs, running counters and epoch roll-over.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_result_valid  <= 1'b0;
            o_result        <= 2'b00;
            o_winner        <= 10'd0;
            o_correct_cnt   <= '0;
            o_scored_cnt    <= '0;
            o_epoch_done    <= 1'b0;
            o_epoch_correct <= '0;
            o_epoch_idx     <= '0;
        end else begin
            o_result_valid <= 1'b0;
            o_epoch_done   <= 1'b0;
            if (o_scored_cnt == CW'(p_sample_num)) begin
                o_epoch_done    <= 1'b1;
                o_epoch_correct <= o_correct_cnt;
                o_correct_cnt   <= '0;
                o_scored_cnt    <= '0;
                if (o_epoch_idx != EW'(p_epochs)) begin
                    o_epoch_idx <= o_epoch_idx + EW'(1);
                end
            end else if (state_r == ST_SCORE) begin
                o_result_valid <= 1'b1;
                o_result       <= code_s;
                o_winner       <= winner_r;
                o_scored_cnt   <= o_scored_cnt + CW'(1);
                if (code_s == 2'b01) begin
                    o_correct_cnt <= o_correct_cnt + CW'(1);
                end
            end
        end
    end

    // Sticky error flags: overlapping presentation and malformed label.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overrun   <= 1'b0;
            o_label_err <= 1'b0;
        end else if (present_s) begin
            if (state_r != ST_IDLE) begin
                o_overrun <= 1'b1;
            end else if (!label_ok_s) begin
                o_label_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/spike_label_scorer.md
Name: spike_label_scorer

Overview:
- Receive-side counterpart of the digit training stimulus generator.
- Watches each presented 5x5 spike pattern and its one-hot label, then watches the 10-neuron output layer of the digits network for a bounded response window.
- Scores each sample as correct, wrong, or no-response, and reports per-epoch accuracy totals for the bench and for on-chip monitoring.

Parameters:
- p_sample_num, 30: scored samples per epoch.
- p_window, 200: response-window length in clock cycles after presentation.
- p_epochs, 400: epoch index saturation value.

Ports:
- i_clk  input  1  clock; sampled on the rising edge (the generator drives on the falling edge).
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_test_vector  input  25 [25:1]  presented pixel spikes; nonzero for exactly one cycle per sample.
- i_label  input  10 [10:1]  one-hot class label, valid in the same cycle as i_test_vector.
- i_out_spikes  input  10 [10:1]  output-layer neuron spikes.
- o_result_valid  output  1  one-cycle pulse when a sample is scored.
- o_result  output  2  00 = no-response, 01 = correct, 10 = wrong; held until the next score.
- o_winner  output  10 [10:1]  one-hot winning neuron; 0 if no response; held.
- o_correct_cnt  output  $clog2(p_sample_num+1)  running correct count, current epoch.
- o_scored_cnt  output  $clog2(p_sample_num+1)  running scored count, current epoch.
- o_epoch_done  output  1  one-cycle pulse at epoch end.
- o_epoch_correct  output  $clog2(p_sample_num+1)  correct total of the last completed epoch; held.
- o_epoch_idx  output  $clog2(p_epochs+1)  completed epochs; saturates at p_epochs.
- o_overrun  output  1  sticky: a presentation arrived while not IDLE.
- o_label_err  output  1  sticky: a presentation arrived with a non-one-hot label.

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs 0, state IDLE.
  - Counters, latched label and winner cleared.
  - Reset mid-window discards the sample with no score.
- Presentation is detected when i_test_vector != 0.
- IDLE:
  - On presentation with a one-hot i_label: latch the label, clear the window counter, go to WINDOW.
  - On presentation with a zero or multi-hot label: set o_label_err, stay IDLE; the sample is not scored.
  - A label without a pattern is ignored.
- WINDOW:
  - The counter increments every cycle, starting with the cycle after presentation.
  - First cycle with i_out_spikes != 0 and the winner still unset: winner = lowest-index set bit, one-hot. Later spikes are ignored.
  - A spike in the presentation cycle itself is ignored.
  - When the counter reaches p_window-1, go to SCORE. The window is exactly p_window cycles.
  - A presentation during WINDOW or SCORE sets o_overrun; that sample is dropped and the current sample continues.
- SCORE (one cycle):
  - o_result: 00 if winner == 0; 01 if winner == latched label; 10 otherwise.
  - Pulse o_result_valid; o_winner and o_result register at the same edge.
  - Increment o_scored_cnt, and o_correct_cnt if correct.
  - Go to IDLE.
- Epoch end:
  - Occurs when scored reaches p_sample_num in the SCORE cycle.
  - Next cycle: o_epoch_done pulses, o_epoch_correct = final correct count, o_epoch_idx += 1 (saturating), running counters clear to 0.
- Latency: o_result_valid is asserted p_window+1 cycles after the presentation edge.
- The block is back-to-back ready: IDLE is reached one cycle after SCORE, and the generator's minimum spacing (pattern delay + 2) exceeds this when p_window <= pattern delay.
- Counter width rule: counts never exceed p_sample_num, so there is no wrap. o_epoch_idx holds at p_epochs.
- Sticky flags clear only on reset.

Test Plan:
- Pattern 0x1F, label 10'b0000000100, output spike on bit 3 at cycle 50 -> o_result_valid at cycle 201, o_result = 01, o_winner = 0x004, o_correct_cnt = 1, o_scored_cnt = 1.
- Same label, spikes on bits 5 and 7 together at cycle 10 -> o_winner = 0x010 (lowest index), o_result = 10, o_correct_cnt unchanged.
- No output spikes within 200 cycles, then a spike at cycle 205 -> o_result = 00, o_winner = 0; the late spike is ignored and the next sample is unaffected.
- 30 samples with 21 correct -> o_epoch_done pulses once, o_epoch_correct = 21, o_epoch_idx = 1, o_correct_cnt and o_scored_cnt = 0 the following cycle; repeat 401 epochs -> o_epoch_idx holds at 400.
- Second presentation at cycle 100 of a window -> o_overrun = 1, the first sample is scored normally, o_scored_cnt increments by 1 only.
- Presentation with label 0x003 -> o_label_err = 1, no o_result_valid; assert i_rst_n low mid-window -> all outputs 0 immediately, no score pulse after release.
